// File: rtl/pixel_state.sv
// pixel_state: free-running frame sequencer for a CMOS pixel-sensor array.
// Steps through IDLE -> ERASE -> EXPOSE -> CONVERT -> READ(row 0..V-1) and
// repeats forever. Every phase lasts a fixed number of clock cycles. All
// outputs are decoded from registered state only.

module pixel_state #(
    parameter int VERTICAL_PIXELS = 2,
    parameter int IDLE_CYCLES     = 2,
    parameter int ERASE_CYCLES    = 5,
    parameter int EXPOSE_CYCLES   = 255,
    parameter int CONVERT_CYCLES  = 255,
    parameter int READ_CYCLES     = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       erase,
    output logic                       expose,
    output logic                       convert,
    output logic [VERTICAL_PIXELS-1:0] read
);

    // Find the longest phase so that one shared counter can time every phase.
    localparam int MAX_AB     = (IDLE_CYCLES  > ERASE_CYCLES)   ? IDLE_CYCLES  : ERASE_CYCLES;
    localparam int MAX_CD     = (EXPOSE_CYCLES > CONVERT_CYCLES) ? EXPOSE_CYCLES : CONVERT_CYCLES;
    localparam int MAX_ABCD   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_CYCLES = (MAX_ABCD > READ_CYCLES) ? MAX_ABCD : READ_CYCLES;

    // The counter only has to reach MAX_CYCLES-1. The row index is at least 1 bit wide.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int ROW_W = (VERTICAL_PIXELS > 1) ? $clog2(VERTICAL_PIXELS) : 1;

    // Terminal count for each phase.
    localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST   = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXPOSE_LAST  = CNT_W'(EXPOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONVERT_LAST = CNT_W'(CONVERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(READ_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(VERTICAL_PIXELS - 1);

    // A zero-length phase is meaningless. The conversion ramp is an external
    // 8-bit counter, so a conversion longer than 255 cycles would make it wrap.
    if (VERTICAL_PIXELS < 1) begin : g_bad_rows
        $error("pixel_state: VERTICAL_PIXELS must be at least 1");
    end
    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("pixel_state: IDLE_CYCLES must be at least 1");
    end
    if (ERASE_CYCLES < 1) begin : g_bad_erase
        $error("pixel_state: ERASE_CYCLES must be at least 1");
    end
    if (EXPOSE_CYCLES < 1) begin : g_bad_expose
        $error("pixel_state: EXPOSE_CYCLES must be at least 1");
    end
    if (CONVERT_CYCLES < 1 || CONVERT_CYCLES > 255) begin : g_bad_convert
        $error("pixel_state: CONVERT_CYCLES must be in 1..255");
    end
    if (READ_CYCLES < 1) begin : g_bad_read
        $error("pixel_state: READ_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [CNT_W-1:0]   last_cnt;
    logic               phase_done;

    // Select the terminal count of the phase that is currently running.
    always_comb begin
        last_cnt = IDLE_LAST;
        case (state_q)
            ST_IDLE:    last_cnt = IDLE_LAST;
            ST_ERASE:   last_cnt = ERASE_LAST;
            ST_EXPOSE:  last_cnt = EXPOSE_LAST;
            ST_CONVERT: last_cnt = CONVERT_LAST;
            ST_READ:    last_cnt = READ_LAST;
            default:    last_cnt = IDLE_LAST;
        endcase
        phase_done = (cnt_q == last_cnt);
    end

    // Next-state logic. The counter advances every edge. When a phase ends,
    // the counter clears and the next phase (or next row) starts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        row_d   = row_q;
        if (phase_done) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE:    state_d = ST_ERASE;
                ST_ERASE:   state_d = ST_EXPOSE;
                ST_EXPOSE:  state_d = ST_CONVERT;
                ST_CONVERT: begin
                    state_d = ST_READ;
                    row_d   = '0;
                end
                ST_READ: begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end
            endcase
        end
    end

    // State, counter and row registers. Reset is asynchronous, so the
    // outputs fall as soon as reset asserts, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // Decode the outputs from registered state only. This keeps them mutually
    // exclusive, and read stays one-hot or zero.
    always_comb begin
        erase   = (state_q == ST_ERASE);
        expose  = (state_q == ST_EXPOSE);
        convert = (state_q == ST_CONVERT);
        read    = '0;
        for (int i = 0; i < VERTICAL_PIXELS; i++) begin
            read[i] = (state_q == ST_READ) && (row_q == ROW_W'(i));
        end
    end

endmodule

// File: tb/tb_pixel_state.sv
// tb_pixel_state: scoreboard bench for pixel_state.
// Two instances run side by side: one with the default parameters and one
// with 4 rows of 3 read cycles each. Reset is applied at random times.

module tb_pixel_state;

    localparam int IDLE_C    = 2;
    localparam int ERASE_C   = 5;
    localparam int EXPOSE_C  = 255;
    localparam int CONVERT_C = 255;
    localparam int VP_A      = 2;
    localparam int RC_A      = 5;
    localparam int VP_B      = 4;
    localparam int RC_B      = 3;
    localparam int FRAME_A   = IDLE_C + ERASE_C + EXPOSE_C + CONVERT_C + VP_A * RC_A;

    logic            clk;
    logic            reset;
    logic            erase_a, expose_a, convert_a;
    logic [VP_A-1:0] read_a;
    logic            erase_b, expose_b, convert_b;
    logic [VP_B-1:0] read_b;

    int n_compared   = 0;
    int n_mismatched = 0;
    int model_t      = 0;
    bit running      = 0;

    typedef struct packed {
        logic [6:0] exp_a;
        logic [6:0] exp_b;
    } expect_t;

    expect_t sb_q[$];

    pixel_state #(
        .VERTICAL_PIXELS(VP_A), .IDLE_CYCLES(IDLE_C), .ERASE_CYCLES(ERASE_C),
        .EXPOSE_CYCLES(EXPOSE_C), .CONVERT_CYCLES(CONVERT_C), .READ_CYCLES(RC_A)
    ) u_dut_a (
        .clk(clk), .reset(reset), .erase(erase_a), .expose(expose_a),
        .convert(convert_a), .read(read_a)
    );

    pixel_state #(
        .VERTICAL_PIXELS(VP_B), .IDLE_CYCLES(IDLE_C), .ERASE_CYCLES(ERASE_C),
        .EXPOSE_CYCLES(EXPOSE_C), .CONVERT_CYCLES(CONVERT_C), .READ_CYCLES(RC_B)
    ) u_dut_b (
        .clk(clk), .reset(reset), .erase(erase_b), .expose(expose_b),
        .convert(convert_b), .read(read_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of each DUT's outputs: {erase, expose, convert, read[3:0]}.
    wire [6:0] out_a = {erase_a, expose_a, convert_a, 2'b00, read_a};
    wire [6:0] out_b = {erase_b, expose_b, convert_b, read_b};

    // Reference model. t is the number of rising edges since reset release.
    // The frame is laid out as consecutive windows of the phase lengths.
    function automatic logic [6:0] model_out(input int t, input int vp, input int rc);
        int frame;
        int p;
        logic [6:0] r;
        frame = IDLE_C + ERASE_C + EXPOSE_C + CONVERT_C + vp * rc;
        p = t % frame;
        r = '0;
        if (p < IDLE_C) begin
            r = '0;
        end else if (p < IDLE_C + ERASE_C) begin
            r[6] = 1'b1;
        end else if (p < IDLE_C + ERASE_C + EXPOSE_C) begin
            r[5] = 1'b1;
        end else if (p < IDLE_C + ERASE_C + EXPOSE_C + CONVERT_C) begin
            r[4] = 1'b1;
        end else begin
            r[(p - (IDLE_C + ERASE_C + EXPOSE_C + CONVERT_C)) / rc] = 1'b1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    // Advance one clock. The model steps if the edge saw reset low. Reset may
    // then be asserted or released mid-cycle. The expected outputs for this
    // cycle are pushed onto the scoreboard.
    task automatic applyStimulus(input bit want_reset);
        expect_t e;
        @(posedge clk);
        if (!reset) model_t++;
        #2;
        if (want_reset && !reset) begin
            reset = 1'b1;
            #1;
            checkOutput("async_reset_a", out_a, 7'd0);
            checkOutput("async_reset_b", out_b, 7'd0);
        end else if (!want_reset && reset) begin
            reset = 1'b0;
        end
        if (reset) model_t = 0;
        e.exp_a = reset ? 7'd0 : model_out(model_t, VP_A, RC_A);
        e.exp_b = reset ? 7'd0 : model_out(model_t, VP_B, RC_B);
        sb_q.push_back(e);
        running = 1'b1;
    endtask

    // Monitor: on each falling edge, pop the expected outputs and compare
    // them with the DUTs. Also check that at most one output is high.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                if (running) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL scoreboard_underflow at %0t: got 0 entries expected 1", $time);
                end
            end else begin
                e = sb_q.pop_front();
                checkOutput("outputs_a", out_a, e.exp_a);
                checkOutput("outputs_b", out_b, e.exp_b);
                n_compared++;
                if ($countones(out_a) > 1 || $countones(out_b) > 1) begin
                    n_mismatched++;
                    $display("[TB] FAIL mutual_exclusion at %0t: got a=%b b=%b expected at most one high",
                             $time, out_a, out_b);
                end
            end
        end
    end

    // Test sequence: reset, long free run, reset mid-EXPOSE, then random resets.
    initial begin
        int hold;
        reset = 1'b1;
        $display("[TB] start");
        repeat (3) applyStimulus(1'b1);
        repeat (2400) applyStimulus(1'b0);

        // Run to 100 cycles into EXPOSE (instance A), then reset between edges.
        for (int i = 0; i < FRAME_A && (model_t % FRAME_A) != IDLE_C + ERASE_C + 99; i++) begin
            applyStimulus(1'b0);
        end
        repeat (2) applyStimulus(1'b1);
        repeat (600) applyStimulus(1'b0);

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0 && $urandom_range(0, 299) == 0) hold = $urandom_range(1, 4);
            applyStimulus(hold > 0);
            if (hold > 0) hold--;
        end
        applyStimulus(1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
